// File: rtl/bus_ip_bridge_pkg.sv
// Shared types and constants for the bus-to-IP bridge.
// Read-pipeline slots carry the channel select at the maximum supported width.
package bus_ip_bridge_pkg;

   localparam int ERR_CNT_W = 16;
   localparam int MAX_NCH   = 16;

   function automatic int clog2(input int value);
      int result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   localparam int SLOT_SEL_W = clog2(MAX_NCH);

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_READ,
      ACC_WRITE
   } acc_kind_t;

   typedef struct packed {
      logic                  valid;
      logic [SLOT_SEL_W-1:0] sel;
   } rd_slot_t;

endpackage

// File: rtl/bus_ip_bridge_if.sv
// Bus-master request/response signals of the bridge.
// BUS_DATA stays a plain inout port on the bridge because it is tristated.
interface bus_ip_bridge_if #(
   parameter int ABUSWIDTH = 16
);
   logic                 BUS_RD;
   logic                 BUS_WR;
   logic [ABUSWIDTH-1:0] BUS_ADD;
   logic                 BUS_ERR;

   modport master (output BUS_RD, BUS_WR, BUS_ADD, input BUS_ERR);
   modport slave  (input BUS_RD, BUS_WR, BUS_ADD, output BUS_ERR);
endinterface

// File: rtl/bus_ip_bridge_addr_decode.sv
// Combinational window decoder: per-window hit, lowest-index winner as index
// and one-hot grant, and the address relative to the winning window base.
module bus_ip_bridge_addr_decode
   import bus_ip_bridge_pkg::*;
#(
   parameter int                         NCH       = 4,
   parameter int                         ABUSWIDTH = 16,
   parameter logic [NCH*ABUSWIDTH-1:0]   BASEADDRS = '0,
   parameter logic [NCH*ABUSWIDTH-1:0]   HIGHADDRS = '0
) (
   input  logic [ABUSWIDTH-1:0]  addr,
   output logic [NCH-1:0]        hit,
   output logic [NCH-1:0]        grant,
   output logic [SLOT_SEL_W-1:0] sel,
   output logic [ABUSWIDTH-1:0]  rel_add
);

   // Scanning from the top down lets the lowest matching window overwrite the rest.
   always_comb begin
      hit     = '0;
      grant   = '0;
      sel     = '0;
      rel_add = '0;
      for (int i = 0; i < NCH; i++) begin
         hit[i] = (addr >= BASEADDRS[i*ABUSWIDTH +: ABUSWIDTH]) &&
                  (addr <= HIGHADDRS[i*ABUSWIDTH +: ABUSWIDTH]);
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (hit[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            sel      = SLOT_SEL_W'(i);
            rel_add  = addr - BASEADDRS[i*ABUSWIDTH +: ABUSWIDTH];
         end
      end
   end

endmodule

// File: rtl/bus_ip_bridge.sv
// Registered multi-window bridge from the BUS_* master bus to NCH IP register
// ports, with a fixed-latency read return and a saturating error counter.
module bus_ip_bridge
   import bus_ip_bridge_pkg::*;
#(
   parameter int                         NCH       = 4,
   parameter int                         ABUSWIDTH = 16,
   parameter int                         DBUSWIDTH = 8,
   parameter logic [NCH*ABUSWIDTH-1:0]   BASEADDRS = '0,
   parameter logic [NCH*ABUSWIDTH-1:0]   HIGHADDRS = '0,
   parameter int                         IP_RD_LAT = 1
) (
   input  logic                     BUS_CLK,
   input  logic                     BUS_RST,
   bus_ip_bridge_if.slave           bus,
   inout  wire  [DBUSWIDTH-1:0]     BUS_DATA,
   output logic [NCH-1:0]           IP_RD,
   output logic [NCH-1:0]           IP_WR,
   output logic [ABUSWIDTH-1:0]     IP_ADD,
   output logic [DBUSWIDTH-1:0]     IP_DATA_IN,
   input  logic [NCH*DBUSWIDTH-1:0] IP_DATA_OUT,
   output logic [ERR_CNT_W-1:0]     ERR_CNT
);

   localparam int RLAT = 1 + IP_RD_LAT;

   logic [NCH-1:0]        hit;
   logic [NCH-1:0]        grant;
   logic [SLOT_SEL_W-1:0] sel;
   logic [ABUSWIDTH-1:0]  rel_add;
   acc_kind_t             acc_kind;
   logic                  err_now;
   rd_slot_t              rd_pipe [RLAT];
   logic                  ret_en;
   logic [DBUSWIDTH-1:0]  ret_data;

   bus_ip_bridge_addr_decode #(
      .NCH       (NCH),
      .ABUSWIDTH (ABUSWIDTH),
      .BASEADDRS (BASEADDRS),
      .HIGHADDRS (HIGHADDRS)
   ) u_decode (
      .addr    (bus.BUS_ADD),
      .hit     (hit),
      .grant   (grant),
      .sel     (sel),
      .rel_add (rel_add)
   );

   // A simultaneous RD and WR is treated as a write and also flagged as an error.
   always_comb begin
      acc_kind = ACC_IDLE;
      if (bus.BUS_WR)      acc_kind = ACC_WRITE;
      else if (bus.BUS_RD) acc_kind = ACC_READ;
      err_now = (acc_kind != ACC_IDLE) && (!(|hit) || (bus.BUS_RD && bus.BUS_WR));
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         IP_RD       <= '0;
         IP_WR       <= '0;
         IP_ADD      <= '0;
         IP_DATA_IN  <= '0;
         bus.BUS_ERR <= 1'b0;
         ERR_CNT     <= '0;
      end else begin
         IP_RD       <= (acc_kind == ACC_READ)  ? grant : '0;
         IP_WR       <= (acc_kind == ACC_WRITE) ? grant : '0;
         bus.BUS_ERR <= err_now;
         if ((acc_kind != ACC_IDLE) && (|hit)) begin
            IP_ADD     <= rel_add;
            IP_DATA_IN <= BUS_DATA;
         end
         if (err_now && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + 1'b1;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         for (int i = 0; i < RLAT; i++) rd_pipe[i] <= '0;
      end else begin
         rd_pipe[0].valid <= (acc_kind == ACC_READ) && (|hit);
         rd_pipe[0].sel   <= sel;
         for (int i = 1; i < RLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   // The tail slot selects straight from the IP outputs, so a zero IP latency
   // returns the IP's combinational data one cycle after the request.
   always_comb begin
      ret_en   = rd_pipe[RLAT-1].valid;
      ret_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd_pipe[RLAT-1].sel == SLOT_SEL_W'(i))
            ret_data = IP_DATA_OUT[i*DBUSWIDTH +: DBUSWIDTH];
      end
   end

   assign BUS_DATA = ret_en ? ret_data : 'z;

endmodule

// File: tb/tb_bus_ip_bridge.sv
// Directed self-checking bench for bus_ip_bridge: a four-window instance and a
// two-window instance with overlapping windows.
module tb_bus_ip_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          tests_run = 0;
   int          failed = 0;

   bus_ip_bridge_if #(.ABUSWIDTH(16)) bus_if ();
   wire  [7:0]  bus_data;
   logic        tb_drv = 1'b0;
   logic [7:0]  tb_wdata = 8'h00;
   logic [3:0]  ip_rd;
   logic [3:0]  ip_wr;
   logic [15:0] ip_add;
   logic [7:0]  ip_din;
   logic [31:0] ip_dout = {8'h44, 8'h3C, 8'h22, 8'h11};
   logic [15:0] err_cnt;

   bus_ip_bridge_if #(.ABUSWIDTH(16)) bus_ovl ();
   wire  [7:0]  bus_data_ovl;
   logic [1:0]  ip_rd_ovl;
   logic [1:0]  ip_wr_ovl;
   logic [15:0] ip_add_ovl;
   logic [7:0]  ip_din_ovl;
   logic [15:0] ip_dout_ovl = {8'h77, 8'h66};
   logic [15:0] err_cnt_ovl;

   assign bus_data = tb_drv ? tb_wdata : 8'bz;

   always #5 clk = ~clk;

   bus_ip_bridge #(
      .NCH       (4),
      .ABUSWIDTH (16),
      .DBUSWIDTH (8),
      .BASEADDRS (64'h8000_1000_0100_0000),
      .HIGHADDRS (64'hFFFF_10FF_01FF_00FF),
      .IP_RD_LAT (1)
   ) dut (
      .BUS_CLK     (clk),
      .BUS_RST     (rst),
      .bus         (bus_if),
      .BUS_DATA    (bus_data),
      .IP_RD       (ip_rd),
      .IP_WR       (ip_wr),
      .IP_ADD      (ip_add),
      .IP_DATA_IN  (ip_din),
      .IP_DATA_OUT (ip_dout),
      .ERR_CNT     (err_cnt)
   );

   bus_ip_bridge #(
      .NCH       (2),
      .ABUSWIDTH (16),
      .DBUSWIDTH (8),
      .BASEADDRS (32'h0100_0000),
      .HIGHADDRS (32'h01FF_01FF),
      .IP_RD_LAT (1)
   ) dut_ovl (
      .BUS_CLK     (clk),
      .BUS_RST     (rst),
      .bus         (bus_ovl),
      .BUS_DATA    (bus_data_ovl),
      .IP_RD       (ip_rd_ovl),
      .IP_WR       (ip_wr_ovl),
      .IP_ADD      (ip_add_ovl),
      .IP_DATA_IN  (ip_din_ovl),
      .IP_DATA_OUT (ip_dout_ovl),
      .ERR_CNT     (err_cnt_ovl)
   );

   // An undriven net reads Z on 4-state simulators and 0 on 2-state ones;
   // no IP in these tests ever returns 0x00, so either means "not driven".
   function automatic bit is_undriven(input logic [7:0] v);
      return (v === 8'hzz) || (v === 8'h00);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic drv, input logic [7:0] wdata);
      bus_if.BUS_RD  = rd;
      bus_if.BUS_WR  = wr;
      bus_if.BUS_ADD = addr;
      tb_drv         = drv;
      tb_wdata       = wdata;
   endtask

   task automatic test_reset();
      tests_run++;
      if (ip_rd !== 4'b0000 || ip_wr !== 4'b0000) begin
         failed++;
         $display("[TB] FAIL reset_strobes: rd=%b wr=%b, expected 0000/0000", ip_rd, ip_wr);
      end
      tests_run++;
      if (ip_add !== 16'h0000 || ip_din !== 8'h00) begin
         failed++;
         $display("[TB] FAIL reset_regs: add=%h din=%h, expected 0000/00", ip_add, ip_din);
      end
      tests_run++;
      if (bus_if.BUS_ERR !== 1'b0 || err_cnt !== 16'h0000) begin
         failed++;
         $display("[TB] FAIL reset_err: err=%b cnt=%h, expected 0/0000", bus_if.BUS_ERR, err_cnt);
      end
      tests_run++;
      if (!is_undriven(bus_data)) begin
         failed++;
         $display("[TB] FAIL reset_bus_data: got %h, expected Z", bus_data);
      end
   endtask

   task automatic test_write();
      applyStimulus(1'b0, 1'b1, 16'h0105, 1'b1, 8'hA5);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      tests_run++;
      if (ip_wr !== 4'b0010 || ip_rd !== 4'b0000) begin
         failed++;
         $display("[TB] FAIL write_strobe: wr=%b rd=%b, expected 0010/0000", ip_wr, ip_rd);
      end
      tests_run++;
      if (ip_add !== 16'h0005 || ip_din !== 8'hA5) begin
         failed++;
         $display("[TB] FAIL write_addr_data: add=%h din=%h, expected 0005/a5", ip_add, ip_din);
      end
      tick();
      tests_run++;
      if (ip_wr !== 4'b0000 || ip_add !== 16'h0005) begin
         failed++;
         $display("[TB] FAIL write_one_cycle: wr=%b add=%h, expected 0000/0005", ip_wr, ip_add);
      end
   endtask

   task automatic test_read();
      applyStimulus(1'b1, 1'b0, 16'h1003, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      tests_run++;
      if (ip_rd !== 4'b0100 || ip_add !== 16'h0003) begin
         failed++;
         $display("[TB] FAIL read_strobe: rd=%b add=%h, expected 0100/0003", ip_rd, ip_add);
      end
      tests_run++;
      if (!is_undriven(bus_data)) begin
         failed++;
         $display("[TB] FAIL read_early: got %h, expected Z", bus_data);
      end
      tick();
      tests_run++;
      if (bus_data !== 8'h3C || ip_rd !== 4'b0000) begin
         failed++;
         $display("[TB] FAIL read_return: data=%h rd=%b, expected 3c/0000", bus_data, ip_rd);
      end
      tick();
      tests_run++;
      if (!is_undriven(bus_data)) begin
         failed++;
         $display("[TB] FAIL read_late: got %h, expected Z", bus_data);
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(1'b1, 1'b0, 16'h0001, 1'b0, 8'h00);
      tick();
      tests_run++;
      if (ip_rd !== 4'b0001) begin
         failed++;
         $display("[TB] FAIL b2b_strobe0: got %b, expected 0001", ip_rd);
      end
      applyStimulus(1'b1, 1'b0, 16'h0101, 1'b0, 8'h00);
      tick();
      tests_run++;
      if (ip_rd !== 4'b0010 || bus_data !== 8'h11) begin
         failed++;
         $display("[TB] FAIL b2b_ret0: rd=%b data=%h, expected 0010/11", ip_rd, bus_data);
      end
      applyStimulus(1'b1, 1'b0, 16'h8000, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      tests_run++;
      if (ip_rd !== 4'b1000 || ip_add !== 16'h0000 || bus_data !== 8'h22) begin
         failed++;
         $display("[TB] FAIL b2b_ret1: rd=%b add=%h data=%h, expected 1000/0000/22",
                  ip_rd, ip_add, bus_data);
      end
      tick();
      tests_run++;
      if (bus_data !== 8'h44) begin
         failed++;
         $display("[TB] FAIL b2b_ret2: got %h, expected 44", bus_data);
      end
      tick();
      tests_run++;
      if (!is_undriven(bus_data)) begin
         failed++;
         $display("[TB] FAIL b2b_after: got %h, expected Z", bus_data);
      end
   endtask

   task automatic test_unmapped();
      applyStimulus(1'b1, 1'b0, 16'h2000, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      tests_run++;
      if (ip_rd !== 4'b0000 || ip_wr !== 4'b0000 || bus_if.BUS_ERR !== 1'b1) begin
         failed++;
         $display("[TB] FAIL unmapped_err: rd=%b wr=%b err=%b, expected 0000/0000/1",
                  ip_rd, ip_wr, bus_if.BUS_ERR);
      end
      tick();
      tests_run++;
      if (!is_undriven(bus_data) || bus_if.BUS_ERR !== 1'b0) begin
         failed++;
         $display("[TB] FAIL unmapped_slot: data=%h err=%b, expected Z/0", bus_data, bus_if.BUS_ERR);
      end
      tests_run++;
      if (err_cnt !== 16'h0001) begin
         failed++;
         $display("[TB] FAIL unmapped_cnt: got %h, expected 0001", err_cnt);
      end
   endtask

   task automatic test_rd_wr_together();
      applyStimulus(1'b1, 1'b1, 16'h0010, 1'b1, 8'h5A);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      tests_run++;
      if (ip_wr !== 4'b0001 || ip_rd !== 4'b0000 || bus_if.BUS_ERR !== 1'b1) begin
         failed++;
         $display("[TB] FAIL rdwr_strobe: wr=%b rd=%b err=%b, expected 0001/0000/1",
                  ip_wr, ip_rd, bus_if.BUS_ERR);
      end
      tests_run++;
      if (ip_add !== 16'h0010 || ip_din !== 8'h5A) begin
         failed++;
         $display("[TB] FAIL rdwr_data: add=%h din=%h, expected 0010/5a", ip_add, ip_din);
      end
      tick();
      tests_run++;
      if (!is_undriven(bus_data) || err_cnt !== 16'h0002) begin
         failed++;
         $display("[TB] FAIL rdwr_after: data=%h cnt=%h, expected Z/0002", bus_data, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      applyStimulus(1'b1, 1'b0, 16'h0010, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      rst = 1'b1;
      tests_run++;
      if (ip_rd !== 4'b0001) begin
         failed++;
         $display("[TB] FAIL rstmid_inflight: got %b, expected 0001", ip_rd);
      end
      tick();
      rst = 1'b0;
      tests_run++;
      if (ip_rd !== 4'b0000 || !is_undriven(bus_data)) begin
         failed++;
         $display("[TB] FAIL rstmid_drop: rd=%b data=%h, expected 0000/Z", ip_rd, bus_data);
      end
      tests_run++;
      if (err_cnt !== 16'h0000) begin
         failed++;
         $display("[TB] FAIL rstmid_cnt: got %h, expected 0000", err_cnt);
      end
      tick();
      tests_run++;
      if (!is_undriven(bus_data)) begin
         failed++;
         $display("[TB] FAIL rstmid_after: got %h, expected Z", bus_data);
      end
   endtask

   task automatic test_overlap();
      bus_ovl.BUS_RD  = 1'b1;
      bus_ovl.BUS_ADD = 16'h0150;
      tick();
      bus_ovl.BUS_RD  = 1'b0;
      bus_ovl.BUS_ADD = 16'h0000;
      tests_run++;
      if (ip_rd_ovl !== 2'b01 || ip_add_ovl !== 16'h0150) begin
         failed++;
         $display("[TB] FAIL overlap_strobe: rd=%b add=%h, expected 01/0150", ip_rd_ovl, ip_add_ovl);
      end
      tick();
      tests_run++;
      if (bus_data_ovl !== 8'h66) begin
         failed++;
         $display("[TB] FAIL overlap_return: got %h, expected 66", bus_data_ovl);
      end
   endtask

   task automatic test_saturation();
      applyStimulus(1'b1, 1'b0, 16'h2000, 1'b0, 8'h00);
      repeat (65535) tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      tick();
      tick();
      tests_run++;
      if (err_cnt !== 16'hFFFF) begin
         failed++;
         $display("[TB] FAIL sat_reach: got %h, expected ffff", err_cnt);
      end
      applyStimulus(1'b0, 1'b1, 16'h4000, 1'b1, 8'h99);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      tests_run++;
      if (bus_if.BUS_ERR !== 1'b1 || ip_wr !== 4'b0000) begin
         failed++;
         $display("[TB] FAIL sat_err_pulse: err=%b wr=%b, expected 1/0000", bus_if.BUS_ERR, ip_wr);
      end
      tick();
      tick();
      tests_run++;
      if (err_cnt !== 16'hFFFF) begin
         failed++;
         $display("[TB] FAIL sat_hold: got %h, expected ffff", err_cnt);
      end
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
      bus_ovl.BUS_RD  = 1'b0;
      bus_ovl.BUS_WR  = 1'b0;
      bus_ovl.BUS_ADD = 16'h0000;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_unmapped();
      test_rd_wr_together();
      test_reset_mid();
      test_overlap();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
